// File: rtl/pin_entry_ctrl.sv
// PIN-entry sequencer behind the keypad scanner: repeat suppression, digit buffering,
// code check, timed unlock and failed-attempt lockout. Optional macro: ENTRY_TIMEOUT_EN.
module pin_entry_ctrl #(
    parameter int                   PIN_LEN      = 4,
    parameter logic [4*PIN_LEN-1:0] PIN_CODE     = 16'h1234,
    parameter int                   MAX_FAILS    = 3,
    parameter int                   RELEASE_CYC  = 1_500_000,
    parameter int                   OPEN_CYC     = 250_000_000,
    parameter int                   LOCK_CYC     = 500_000_000,
    parameter int                   IDLE_TIMEOUT = 500_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    output logic [$clog2(PIN_LEN+1)-1:0] digit_count,
    output logic                         entry_active,
    output logic                         ok_pulse,
    output logic                         fail_pulse,
    output logic                         unlocked,
    output logic                         locked
);
    localparam int BUF_W  = 4 * PIN_LEN;
    localparam int CNT_W  = $clog2(PIN_LEN + 1);
    localparam int REL_W  = $clog2(RELEASE_CYC + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
`ifdef ENTRY_TIMEOUT_EN
    localparam int ENTRY_LIMIT = IDLE_TIMEOUT;
`else
    localparam int ENTRY_LIMIT = 0 * IDLE_TIMEOUT;
`endif
    // One shared timer: only one of UNLOCKED / LOCKOUT / ENTRY is ever being timed.
    localparam int TMAX_A = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
    localparam int TMAX   = (TMAX_A > ENTRY_LIMIT) ? TMAX_A : ENTRY_LIMIT;
    localparam int TMR_W  = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PIN_LEN);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCK_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_LOCKOUT} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                hold_q, hold_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic                ok_q, ok_d;
    logic                fail_q, fail_d;

    logic acc, is_digit, is_star, is_hash, match, entry_expired;

    assign acc      = key_valid & ~hold_q;
    assign is_digit = (key_code >= 8'h30) && (key_code <= 8'h39);
    assign is_star  = (key_code == 8'h2A);
    assign is_hash  = (key_code == 8'h23);
    assign match    = (cnt_q == CNT_FULL) && !ovf_q && (buf_q == PIN_CODE);
`ifdef ENTRY_TIMEOUT_EN
    assign entry_expired = (state_q == S_ENTRY) && (timer_q == TMR_W'(IDLE_TIMEOUT - 1));
`else
    assign entry_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            hold_q     <= 1'b0;
            rel_q      <= '0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            rel_q      <= rel_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
        end
    end

    // Hold tracking runs regardless of state so a key held across a transition is seen once.
    always_comb begin
        hold_d = hold_q;
        rel_d  = rel_q;
        if (key_valid) begin
            hold_d = 1'b1;
            rel_d  = '0;
        end else if (hold_q) begin
            if (rel_q == REL_LAST) begin
                hold_d = 1'b0;
                rel_d  = '0;
            end else begin
                rel_d = rel_q + REL_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = '0;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (entry_expired) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (acc) begin
                    if (is_digit) begin
                        if (cnt_q < CNT_FULL) begin
                            // ASCII '0'..'9' carry the digit value in their low nibble.
                            buf_d   = BUF_W'({buf_q, key_code[3:0]});
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = S_ENTRY;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (is_star) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (is_hash && cnt_q != '0) begin
                        state_d = S_CHECK;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                if (state_q == S_ENTRY && state_d == S_ENTRY && !acc)
                    timer_d = timer_q + TMR_W'(1);
`endif
            end
            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
                if (match) begin
                    ok_d       = 1'b1;
                    fail_cnt_d = '0;
                    state_d    = S_UNLOCKED;
                end else begin
                    fail_d     = 1'b1;
                    fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                    state_d    = (fail_cnt_q == FAIL_LAST) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = S_IDLE;
                end else if (acc && is_star) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entry_active = (state_q == S_ENTRY);
        unlocked     = (state_q == S_UNLOCKED);
        locked       = (state_q == S_LOCKOUT);
        ok_pulse     = ok_q;
        fail_pulse   = fail_q;
        digit_count  = cnt_q;
    end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl with short timers; one task per scenario.
module tb_pin_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic [2:0] digit_count;
    logic       entry_active, ok_pulse, fail_pulse, unlocked, locked;

    int checks = 0;
    int errors = 0;

    pin_entry_ctrl #(
        .PIN_LEN(4), .PIN_CODE(16'h1234), .MAX_FAILS(3), .RELEASE_CYC(4),
        .OPEN_CYC(20), .LOCK_CYC(50), .IDLE_TIMEOUT(100)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .digit_count(digit_count), .entry_active(entry_active), .ok_pulse(ok_pulse),
        .fail_pulse(fail_pulse), .unlocked(unlocked), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe a key for one cycle; returns 1 time unit after the capturing edge.
    task automatic strobe(input logic [7:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        strobe(k);
        repeat (4) step();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        repeat (2) step();
        chk("reset_outputs", {digit_count, entry_active, ok_pulse, fail_pulse, unlocked, locked}, 0);
        rst = 1'b0;
        step();
        chk("reset_idle", {digit_count, entry_active}, 0);
        $display("test_reset done");
    endtask

    task automatic test_unlock();
        press("1"); press("2"); press("3"); press("4");
        chk("t1_count4", digit_count, 4);
        chk("t1_entry", entry_active, 1);
        strobe("#");
        chk("t1_check_no_ok_yet", ok_pulse, 0);
        chk("t1_check_entry_low", entry_active, 0);
        step();
        chk("t1_ok_pulse", ok_pulse, 1);
        chk("t1_unlocked", unlocked, 1);
        chk("t1_count_cleared", digit_count, 0);
        step();
        chk("t1_ok_one_cycle", ok_pulse, 0);
        for (int i = 0; i < 18; i++) begin
            chk("t1_unlocked_hold", unlocked, 1);
            step();
        end
        chk("t1_unlocked_last", unlocked, 1);
        step();
        chk("t1_relocked", unlocked, 0);
        $display("test_unlock done");
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 10; i++) begin
            strobe("5");
            step(); step();
        end
        chk("t2_repeat_suppressed", digit_count, 1);
        repeat (4) step();
        press("5");
        chk("t2_after_release", digit_count, 2);
        press("*");
        chk("t2_star_clears", digit_count, 0);
        chk("t2_star_idle", entry_active, 0);
        $display("test_repeat done");
    endtask

    task automatic wrong_entry();
        press("1"); press("2"); press("3"); press("5");
        strobe("#");
        step();
    endtask

    task automatic test_lockout();
        for (int a = 0; a < 2; a++) begin
            wrong_entry();
            chk("t3_fail_pulse", fail_pulse, 1);
            chk("t3_not_locked", locked, 0);
            repeat (4) step();
        end
        wrong_entry();
        chk("t3_fail_pulse3", fail_pulse, 1);
        chk("t3_locked", locked, 1);
        for (int i = 1; i < 50; i++) begin
            key_valid = (i % 5 == 1);
            key_code  = (i % 10 == 1) ? 8'h31 : 8'h23;
            step();
            chk("t3_locked_hold", locked, 1);
            chk("t3_keys_ignored", digit_count, 0);
        end
        key_valid = 1'b0;
        step();
        chk("t3_lock_expired", locked, 0);
        repeat (4) step();
        wrong_entry();
        chk("t3_failcnt_cleared_fail", fail_pulse, 1);
        chk("t3_failcnt_cleared_nolock", locked, 0);
        repeat (4) step();
        press("1"); press("2"); press("3"); press("4");
        strobe("#"); step();
        chk("t3_ok_after_lock", ok_pulse, 1);
        repeat (4) step();
        strobe("*");
        chk("t3_early_relock", unlocked, 0);
        repeat (4) step();
        $display("test_lockout done");
    endtask

    task automatic test_overflow();
        press("1"); press("2"); press("3"); press("4"); press("5");
        chk("t4_overflow_count", digit_count, 4);
        strobe("#"); step();
        chk("t4_overflow_fail", fail_pulse, 1);
        chk("t4_overflow_ok_low", ok_pulse, 0);
        repeat (4) step();
        press("1"); press("2"); press("*");
        chk("t4_star_mid", digit_count, 0);
        press("1"); press("2"); press("3"); press("4");
        strobe("#"); step();
        chk("t4_ok_after_star", ok_pulse, 1);
        repeat (4) step();
        press("*");
        chk("t4_relock", unlocked, 0);
        press("A");
        chk("t4_letter_ignored", {digit_count, entry_active}, 0);
        strobe("#");
        chk("t4_lone_hash_entry", entry_active, 0);
        step();
        chk("t4_lone_hash_no_resp", {ok_pulse, fail_pulse, unlocked, locked}, 0);
        repeat (4) step();
        $display("test_overflow done");
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 3; a++) begin
            wrong_entry();
            repeat (4) step();
        end
        chk("t5_in_lockout", locked, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_lockout", {digit_count, entry_active, ok_pulse, fail_pulse, unlocked, locked}, 0);
        #3 rst = 1'b0;
        step();
        press("1"); press("2");
        chk("t5_entry_count", digit_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_entry", {digit_count, entry_active}, 0);
        #3 rst = 1'b0;
        step();
        press("1"); press("2"); press("3"); press("4");
        strobe("#"); step();
        chk("t5_ok_after_rst", ok_pulse, 1);
        repeat (4) step();
        press("*");
        $display("test_async_reset done");
    endtask

`ifdef ENTRY_TIMEOUT_EN
    task automatic test_entry_timeout();
        int fails = 0;
        press("1");
        for (int i = 0; i < 95; i++) begin
            step();
            fails += fail_pulse;
        end
        chk("t6_before_timeout", digit_count, 1);
        step();
        fails += fail_pulse;
        chk("t6_timeout_count", digit_count, 0);
        chk("t6_timeout_entry", entry_active, 0);
        step();
        fails += fail_pulse;
        chk("t6_no_fail_pulse", fails, 0);
        $display("test_entry_timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_unlock();
        test_repeat();
        test_lockout();
        test_overflow();
        test_async_reset();
`ifdef ENTRY_TIMEOUT_EN
        test_entry_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
